// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with PWM brightness,
// leading-zero suppression and a per-frame snapshot of the display inputs.
module seg7_scan_ctrl #(
    parameter int N_DIGITS       = 8,
    parameter int SUB_DIV        = 6510,
    parameter int BRIGHT_W       = 4,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic                  lz_suppress,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [6:0]            catodos,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   anodos,
    output logic                  frame_tick
);

    localparam int SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] B_MAX = '1;
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_OFF =
        (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [SUB_W-1:0]      sub_q, sub_d;
    logic [BRIGHT_W-1:0]   phase_q, phase_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] data_q, data_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [N_DIGITS-1:0]   blank_q, blank_d;
    logic                  lz_q, lz_d;
    logic [BRIGHT_W-1:0]   bright_q, bright_d;
    logic [6:0]            catodos_q, catodos_d;
    logic                  dp_out_q, dp_out_d;
    logic [N_DIGITS-1:0]   anodos_q, anodos_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  snap;
    logic                  sub_wrap;
    logic                  phase_wrap;
    logic [N_DIGITS-1:0]   supp;
    logic                  zero_run;
    logic [3:0]            nib;
    logic                  pwm_on;
    logic                  an_on;
    logic                  seg_on;
    logic [6:0]            seg_hi;
    logic [N_DIGITS-1:0]   an_hot;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        sub_wrap   = (sub_q == SUB_LAST);
        phase_wrap = (phase_q == B_MAX);
        snap = (idx_q == '0) && (phase_q == '0) && (sub_q == '0);

        sub_d   = sub_wrap ? '0 : sub_q + 1'b1;
        phase_d = sub_wrap ? phase_q + 1'b1 : phase_q;
        idx_d   = idx_q;
        if (sub_wrap && phase_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // The snapshot cycle already displays digit 0 of the new frame,
        // so it decodes straight from the inputs being captured.
        data_d   = snap ? data        : data_q;
        dp_d     = snap ? dp          : dp_q;
        blank_d  = snap ? blank       : blank_q;
        lz_d     = snap ? lz_suppress : lz_q;
        bright_d = snap ? brightness  : bright_q;

        supp     = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (data_d[4*i +: 4] == 4'h0);
            supp[i]  = lz_d && zero_run;
        end

        nib    = data_d[4*int'(idx_q) +: 4];
        pwm_on = (bright_d == B_MAX) || (phase_q < bright_d);
        // A suppressed digit keeps its anode only to light its dp.
        an_on  = !blank_d[idx_q] && pwm_on && (!supp[idx_q] || dp_d[idx_q]);
        seg_on = an_on && !supp[idx_q];
        seg_hi = hex7(nib);
        an_hot = N_DIGITS'(1) << idx_q;

        anodos_d = AN_OFF;
        if (an_on) begin
            anodos_d = (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
        end
        catodos_d = SEG_OFF;
        if (seg_on) begin
            catodos_d = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
        end
        dp_out_d = DP_OFF;
        if (an_on && dp_d[idx_q]) begin
            dp_out_d = !DP_OFF;
        end
        frame_tick_d = snap;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            sub_q        <= '0;
            phase_q      <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            dp_q         <= '0;
            blank_q      <= '0;
            lz_q         <= 1'b0;
            bright_q     <= '0;
            catodos_q    <= SEG_OFF;
            dp_out_q     <= DP_OFF;
            anodos_q     <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            sub_q        <= sub_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            lz_q         <= lz_d;
            bright_q     <= bright_d;
            catodos_q    <= catodos_d;
            dp_out_q     <= dp_out_d;
            anodos_q     <= anodos_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign catodos    = catodos_q;
    assign dp_out     = dp_out_q;
    assign anodos     = anodos_q;
    assign frame_tick = frame_tick_q;

endmodule
